adc_ring_writer: RTL and testbench

Parametrised capture engine between the multimeter ADC sample stream and the FPGA-side s2 port of an on-chip dual-port RAM. Accepts tagged samples from up to NUM_CH channels, filters them by channel mask, and writes them into the RAM as a ring (continuous) or fixed-length (single-shot) buffer. Exposes pointer, count and status for HPS software through PIO bits. Generalises the fixed 16-bit/512-word capture path to any width, depth and channel count.

---
 rtl/adc_ring_pkg.sv | 34 +++
 rtl/adc_ring_ptr.sv | 40 ++++
 rtl/adc_ring_writer.sv | 134 +++++++++++++
 tb/tb_adc_ring_writer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ring_pkg.sv
// Shared types and helpers for the ADC ring-buffer capture engine.
package adc_ring_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Capture modes as seen on cfg_mode.
  localparam logic MODE_RING   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  // Widest RAM word the packing helper handles.
  localparam int PACK_MAX_W = 64;

  // Build a RAM word: channel tag in the top ch_w bits, sample in the low
  // sample_w bits, zeros in between. Callers truncate to their word width.
  function automatic logic [PACK_MAX_W-1:0] pack_word(
    input int                    data_w,
    input int                    sample_w,
    input int                    ch_w,
    input logic [PACK_MAX_W-1:0] ch,
    input logic [PACK_MAX_W-1:0] sample
  );
    logic [PACK_MAX_W-1:0] ch_mask;
    logic [PACK_MAX_W-1:0] s_mask;
    ch_mask = {PACK_MAX_W{1'b1}} >> (PACK_MAX_W - ch_w);
    s_mask  = {PACK_MAX_W{1'b1}} >> (PACK_MAX_W - sample_w);
    return ((ch & ch_mask) << (data_w - ch_w)) | (sample & s_mask);
  endfunction

endpackage

// File: rtl/adc_ring_ptr.sv
// Write pointer (wraps modulo the RAM depth) and saturating word counter.
module adc_ring_ptr
  import adc_ring_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   count,
  output logic              wrap,
  output logic              full
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // The current write lands on the last address, so the pointer wraps next.
  assign wrap = (wr_ptr == {ADDR_W{1'b1}});
  // The counter has reached the RAM depth and stops there.
  assign full = (count == DEPTH);

  // Advance pointer and count on every committed write; clear on (re)start.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (inc) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adc_ring_writer.sv
// Capture engine: filters tagged ADC samples by channel and writes them to the
// s2 port of a dual-port RAM as a continuous ring or a single-shot buffer.
module adc_ring_writer
  import adc_ring_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 12,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CH_W-1:0]     s_channel,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic [NUM_CH-1:0]   cfg_ch_mask,
  input  logic                cfg_mode,
  input  logic [ADDR_W:0]     cfg_length,
  input  logic                start,
  input  logic                abort,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                irq
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              state;
  logic                mode_q;
  logic [NUM_CH-1:0]   mask_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     len_eff;
  logic                accept;
  logic                keep;
  logic                write_en;
  logic                last;
  logic                restart;
  logic                wrap;
  logic                full;

  // A start pulse also blocks acceptance so a restart never swallows a sample.
  assign s_ready  = (state == RUN) && !abort && !start;
  assign accept   = s_valid && s_ready;
  assign keep     = ({1'b0, s_channel} < (CH_W+1)'(NUM_CH)) && mask_q[s_channel];
  assign restart  = start && !abort;
  assign len_eff  = (len_q == '0) ? DEPTH : len_q;

  assign busy           = (state == RUN);
  assign done           = (state == DONE);
  assign mem_chipselect = mem_write;
  assign mem_byteenable = '1;
  assign mem_clken      = ~reset_reset;

  // Decide whether this cycle's sample is written and whether it ends a single-shot run.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    write_en = 1'b0;
    last     = 1'b0;
    if (accept && keep) begin
      write_en = 1'b1;
      last     = (mode_q == MODE_SINGLE) && ((count + (ADDR_W+1)'(1)) == len_eff);
    end
  end

  adc_ring_ptr #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk    (clk_clk),
    .rst    (reset_reset),
    .clear  (restart),
    .inc    (write_en),
    .wr_ptr (wr_ptr),
    .count  (count),
    .wrap   (wrap),
    .full   (full)
  );

  // Capture state machine; configuration is latched on start and held for the run.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state  <= IDLE;
      mode_q <= MODE_RING;
      mask_q <= '0;
      len_q  <= '0;
    end else if (abort) begin
      if (state == RUN) state <= IDLE;
    end else if (start) begin
      state  <= RUN;
      mode_q <= cfg_mode;
      mask_q <= cfg_ch_mask;
      len_q  <= cfg_length;
    end else if (last) begin
      state <= DONE;
    end
  end

  // Register the RAM write one cycle after acceptance, plus irq and sticky overflow.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      irq           <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      mem_write <= write_en;
      irq       <= write_en && ((mode_q == MODE_SINGLE) ? last : wrap);
      if (write_en) begin
        mem_address   <= wr_ptr;
        mem_writedata <= DATA_W'(pack_word(DATA_W, SAMPLE_W, CH_W,
                                           PACK_MAX_W'(s_channel),
                                           PACK_MAX_W'(s_data)));
      end
      if (restart) begin
        overflow <= 1'b0;
      end else if (write_en && (mode_q == MODE_RING) && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_ring_writer.sv
// Randomised scoreboard bench for adc_ring_writer with a behavioural capture model.
module tb_adc_ring_writer;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 9;
  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 12;
  localparam int CH_W     = 2;
  localparam int DEPTH    = 1 << ADDR_W;

  logic                clk_clk = 1'b0;
  logic                reset_reset;
  logic                s_valid;
  logic                s_ready;
  logic [CH_W-1:0]     s_channel;
  logic [SAMPLE_W-1:0] s_data;
  logic [NUM_CH-1:0]   cfg_ch_mask;
  logic                cfg_mode;
  logic [ADDR_W:0]     cfg_length;
  logic                start;
  logic                abort;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     count;
  logic                busy;
  logic                done;
  logic                overflow;
  logic                irq;

  adc_ring_writer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_channel      (s_channel),
    .s_data         (s_data),
    .cfg_ch_mask    (cfg_ch_mask),
    .cfg_mode       (cfg_mode),
    .cfg_length     (cfg_length),
    .start          (start),
    .abort          (abort),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .wr_ptr         (wr_ptr),
    .count          (count),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .irq            (irq)
  );

  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int irq_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected RAM write, due in a given cycle.
  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              irq;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model of the capture: words written so far, run/done flags, latched config.
  bit                m_run = 0;
  bit                m_done = 0;
  bit                m_ovf = 0;
  bit                m_mode = 0;
  logic [NUM_CH-1:0] m_mask = '0;
  int                m_len = 0;
  int                m_written = 0;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_ovf = 0; m_written = 0;
    exp_q.delete();
  endtask

  // Evaluate one clock cycle of the model at the negative edge, before the DUT's posedge.
  task automatic model_cycle(input logic v, input logic [CH_W-1:0] ch,
                             input logic [SAMPLE_W-1:0] d, input logic st, input logic ab);
    bit   rdy;
    exp_t e;
    rdy = m_run && !ab && !st;
    check("s_ready", s_ready, rdy);
    if (v && rdy && m_mask[ch]) begin
      e.due  = cyc + 1;
      e.addr = ADDR_W'(m_written % DEPTH);
      e.data = DATA_W'(int'(ch) * (2 ** (DATA_W - CH_W)) + int'(d));
      e.irq  = m_mode ? (m_written + 1 == m_len) : (m_written % DEPTH == DEPTH - 1);
      if (!m_mode && m_written >= DEPTH) m_ovf = 1;
      m_written++;
      if (m_mode && m_written == m_len) begin
        m_run  = 0;
        m_done = 1;
      end
      exp_q.push_back(e);
    end
    if (ab) begin
      if (m_run) m_run = 0;
    end else if (st) begin
      m_run = 1; m_done = 0; m_written = 0; m_ovf = 0;
      m_mode = cfg_mode;
      m_mask = cfg_ch_mask;
      m_len  = (cfg_length == 0) ? DEPTH : int'(cfg_length);
    end
  endtask

  // Drive one cycle of stimulus; inputs change just after the posedge.
  task automatic step(input logic v, input logic [CH_W-1:0] ch,
                      input logic [SAMPLE_W-1:0] d, input logic st, input logic ab);
    s_valid = v; s_channel = ch; s_data = d; start = st; abort = ab;
    @(negedge clk_clk);
    model_cycle(v, ch, d, st, ab);
    @(posedge clk_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_status(input string tag);
    int exp_cnt;
    exp_cnt = (m_written > DEPTH) ? DEPTH : m_written;
    check({tag, ".busy"},     busy,     m_run);
    check({tag, ".done"},     done,     m_done);
    check({tag, ".overflow"}, overflow, m_ovf);
    check({tag, ".count"},    count,    exp_cnt);
    check({tag, ".wr_ptr"},   wr_ptr,   m_written % DEPTH);
  endtask

  task automatic begin_capture(input logic mode, input logic [NUM_CH-1:0] mask,
                               input logic [ADDR_W:0] len);
    cfg_mode = mode; cfg_ch_mask = mask; cfg_length = len;
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: compare every cycle's RAM port against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_clk);
      if (irq) irq_seen++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("wr_strobe", mem_write, 1'b1);
        check("wr_addr", mem_address, e.addr);
        check("wr_data", mem_writedata, e.data);
        check("wr_irq", irq, e.irq);
      end else begin
        check("no_write", mem_write, 1'b0);
        check("irq_idle", irq, 1'b0);
      end
      check("cs_eq_we", mem_chipselect, mem_write);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int irq0;
    int pre;
    logic [NUM_CH-1:0] rmask;
    reset_reset = 1'b1;
    s_valid = 0; s_channel = '0; s_data = '0; start = 0; abort = 0;
    cfg_ch_mask = '0; cfg_mode = 0; cfg_length = '0;

    // Reset state.
    #2;
    check("rst.mem_write", mem_write, 0);
    check("rst.mem_clken", mem_clken, 0);
    check("rst.s_ready", s_ready, 0);
    check("rst.irq", irq, 0);
    check_status("rst");
    #20 reset_reset = 1'b0;
    @(posedge clk_clk); #1;
    check("run.mem_clken", mem_clken, 1);
    check("byteenable", mem_byteenable, 2'b11);

    // Single-shot, mask 0101, length 6, channels cycling.
    irq0 = irq_seen;
    begin_capture(1'b1, 4'b0101, 10'd6);
    for (int i = 0; i < 30; i++) step(1'b1, CH_W'(i % 4), SAMPLE_W'(16'h100 + i), 1'b0, 1'b0);
    idle(1);
    check_status("ss6");
    check("ss6.done", done, 1);
    check("ss6.irq_pulses", irq_seen - irq0, 1);

    // Continuous ring: wrap once, overflow after saturation, stop at 517 words.
    irq0 = irq_seen;
    begin_capture(1'b0, 4'b1111, 10'd0);
    for (int i = 0; i < 3000 && m_written < DEPTH + 5; i++)
      step($urandom_range(0, 3) != 0, CH_W'($urandom), SAMPLE_W'($urandom), 1'b0, 1'b0);
    idle(1);
    check_status("ring");
    check("ring.overflow", overflow, 1);
    check("ring.wr_ptr5", wr_ptr, 5);
    check("ring.irq_pulses", irq_seen - irq0, 1);

    // Restart during RUN clears overflow/count; next word goes to address 0.
    begin_capture(1'b0, 4'b1111, 10'd0);
    check_status("restart");
    check("restart.count0", count, 0);
    for (int i = 0; i < 3; i++) step(1'b1, CH_W'(i), SAMPLE_W'($urandom), 1'b0, 1'b0);
    idle(1);
    check_status("restart2");

    // Abort after three accepted samples; the third write still completes.
    begin_capture(1'b0, 4'b1111, 10'd0);
    for (int i = 0; i < 3; i++) step(1'b1, CH_W'(i), SAMPLE_W'($urandom), 1'b0, 1'b0);
    step(1'b1, 2'd3, SAMPLE_W'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, CH_W'(i), SAMPLE_W'($urandom), 1'b0, 1'b0);
    check_status("abort");
    check("abort.count3", count, 3);

    // Random single-shot with scrambled cfg after start (config must stay latched).
    irq0 = irq_seen;
    rmask = NUM_CH'($urandom_range(1, 15));
    begin_capture(1'b1, rmask, ADDR_W'($urandom_range(1, 40)));
    cfg_ch_mask = ~rmask; cfg_mode = 1'b0; cfg_length = 10'd2;
    for (int i = 0; i < 600 && !m_done; i++)
      step($urandom_range(0, 2) != 0, CH_W'($urandom), SAMPLE_W'($urandom), 1'b0, 1'b0);
    idle(2);
    check_status("rand_ss");
    check("rand_ss.irq_pulses", irq_seen - irq0, 1);

    // Single-shot with cfg_length = 0 means the full depth.
    irq0 = irq_seen;
    begin_capture(1'b1, 4'b1111, 10'd0);
    for (int i = 0; i < 3000 && !m_done; i++)
      step($urandom_range(0, 4) != 0, CH_W'($urandom), SAMPLE_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, CH_W'(i), SAMPLE_W'($urandom), 1'b0, 1'b0);
    check_status("len0");
    check("len0.count", count, DEPTH);
    check("len0.done", done, 1);
    check("len0.irq_pulses", irq_seen - irq0, 1);

    // Reset mid-write with s_valid held high: outputs drop immediately, write is lost.
    begin_capture(1'b0, 4'b1111, 10'd0);
    for (int i = 0; i < 4; i++) step(1'b1, CH_W'(i), SAMPLE_W'($urandom), 1'b0, 1'b0);
    pre = mem_write;
    check("prereset.mem_write", pre, 1);
    #1 reset_reset = 1'b1;
    model_reset();
    #1;
    check("midrst.mem_write", mem_write, 0);
    check("midrst.mem_chipselect", mem_chipselect, 0);
    check("midrst.mem_clken", mem_clken, 0);
    check("midrst.mem_address", mem_address, 0);
    check("midrst.mem_writedata", mem_writedata, 0);
    check("midrst.irq", irq, 0);
    check("midrst.s_ready", s_ready, 0);
    check_status("midrst");
    @(negedge clk_clk); @(negedge clk_clk);
    #2 reset_reset = 1'b0;
    @(posedge clk_clk); #1;
    for (int i = 0; i < 4; i++) step(1'b1, CH_W'(i), SAMPLE_W'($urandom), 1'b0, 1'b0);
    check_status("postrst");

    idle(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
